// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the single-cycle MIPS core.
// Holds the opcode/funct encodings, the ALU operation set and the
// next-PC / write-back source selectors used by the decoder in cpu.
package cpu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // SPECIAL2 funct codes
    localparam logic [5:0] FN2_MUL = 6'h02;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_BRANCH,
        PC_JUMP,
        PC_REG
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_LINK
    } wb_src_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 32 x 32-bit register file, two combinational read ports and
// one synchronous write port. r0 always reads as zero and ignores writes.
// Reset clears every register except r29, which is loaded with the stack top.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rs_addr/rs_data   read port A
//   rt_addr/rt_data   read port B
//   we, wr_addr,      write enable, destination and data (taken on the
//   wr_data           rising edge)
module cpu_regfile #(
    parameter logic [31:0] STACK_INIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? STACK_INIT : 32'h0;
            end
        end else if (we && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'h0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'h0 : regs[rt_addr];

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle 32-bit MIPS integer core. Each rising edge fetches,
// executes and commits one instruction from a unified word-organised memory
// that holds both program and data. The memory is never reset, so an image
// loaded before reset is preserved.
//
// Ports:
//   clk    clock; all state updates on the rising edge
//   rst_n  asynchronous active-low reset (PC=0, registers cleared, r29=STACK_INIT)
//   pc_o   current program counter, for debug
module cpu
    import cpu_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] STACK_INIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] data_idx;

    alu_op_e     alu_op;
    pc_src_e     pc_src;
    wb_src_e     wb_src;
    logic        use_imm;
    logic        zero_ext;
    logic        reg_we;
    logic        mem_we;
    logic [4:0]  dest;

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 32'h0;
        end else begin
            pc <= pc_next;
        end
    end

    assign pc_o      = pc;
    assign pc_plus4  = pc + 32'd4;
    assign fetch_idx = pc[AW+1:2];
    assign instr     = mem[fetch_idx];

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign target = instr[25:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    cpu_regfile #(
        .STACK_INIT (STACK_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .we      (reg_we),
        .wr_addr (dest),
        .wr_data (wb_data)
    );

    // ------------------------------------------------------------------
    // Decode. Anything not recognised falls through the defaults: no
    // register write, no memory write, PC+4.
    // ------------------------------------------------------------------
    always_comb begin
        alu_op   = ALU_ADD;
        pc_src   = PC_PLUS4;
        wb_src   = WB_ALU;
        use_imm  = 1'b0;
        zero_ext = 1'b0;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        dest     = rd;

        case (op)
            OP_SPECIAL: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_JR: begin
                        reg_we = 1'b0;
                        pc_src = PC_REG;
                    end
                    FN_JALR: begin
                        pc_src = PC_REG;
                        wb_src = WB_LINK;
                    end
                    default:         reg_we = 1'b0;
                endcase
            end
            OP_SPECIAL2: begin
                if (funct == FN2_MUL) begin
                    alu_op = ALU_MUL;
                    reg_we = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dest    = rt;
            end
            OP_SLTI: begin
                alu_op  = ALU_SLT;
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dest    = rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_op   = (op == OP_ANDI) ? ALU_AND :
                           (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                use_imm  = 1'b1;
                zero_ext = 1'b1;
                reg_we   = 1'b1;
                dest     = rt;
            end
            OP_LUI: begin
                alu_op  = ALU_LUI;
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dest    = rt;
            end
            OP_LW: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dest    = rt;
                wb_src  = WB_MEM;
            end
            OP_SW: begin
                use_imm = 1'b1;
                mem_we  = 1'b1;
            end
            OP_BEQ: begin
                if (rs_val == rt_val) pc_src = PC_BRANCH;
            end
            OP_BNE: begin
                if (rs_val != rt_val) pc_src = PC_BRANCH;
            end
            OP_J: begin
                pc_src = PC_JUMP;
            end
            OP_JAL: begin
                pc_src = PC_JUMP;
                reg_we = 1'b1;
                dest   = 5'd31;
                wb_src = WB_LINK;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    assign imm_ext = zero_ext ? {16'h0, imm16} : sign_ext16(imm16);
    assign alu_a   = rs_val;
    assign alu_b   = use_imm ? imm_ext : rt_val;

    // Shifts operate on the rt operand by the instruction's shamt field.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_NOR:  alu_result = ~(alu_a | alu_b);
            ALU_SLT:  alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_result = {31'b0, (alu_a < alu_b)};
            ALU_SLL:  alu_result = alu_b << shamt;
            ALU_SRL:  alu_result = alu_b >> shamt;
            ALU_SRA:  alu_result = 32'($signed(alu_b) >>> shamt);
            ALU_MUL:  alu_result = alu_a * alu_b;
            ALU_LUI:  alu_result = {alu_b[15:0], 16'h0};
            default:  alu_result = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory: combinational read, word write on the rising edge.
    // ------------------------------------------------------------------
    assign data_idx  = alu_result[AW+1:2];
    assign load_data = mem[data_idx];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[data_idx] <= rt_val;
        end
    end

    // ------------------------------------------------------------------
    // Write-back and next PC
    // ------------------------------------------------------------------
    always_comb begin
        case (wb_src)
            WB_MEM:  wb_data = load_data;
            WB_LINK: wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    // Branch offsets use the sign-extended immediate; branches never set
    // zero_ext, so imm_ext already holds it.
    always_comb begin
        case (pc_src)
            PC_BRANCH: pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
            PC_JUMP:   pc_next = {pc_plus4[31:28], target, 2'b00};
            PC_REG:    pc_next = rs_val;
            default:   pc_next = pc_plus4;
        endcase
    end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [31:0] mreg [32];
    logic [31:0] mmem [4096];
    logic [31:0] mpc;

    logic [31:0] img [64];

    always #5 clk = ~clk;

    cpu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_o  (pc_o)
    );

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_mul(int rs, int rt, int rd);
        return {6'h1C, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h02};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mreg[29] = 32'h0000_3FFC;
        mpc = 32'h0;
    endtask

    // Instruction-level interpreter: one call = one architectural instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, zimm, npc, res, addr;
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh, dst;
        bit          wr;
        ins  = mmem[mpc[13:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        sh   = int'(ins[10:6]);
        a    = mreg[rs];
        b    = mreg[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0, ins[15:0]};
        addr = a + simm;
        npc  = mpc + 32'd4;
        res  = 32'h0;
        wr   = 1'b0;
        dst  = rt;
        case (op)
            6'h00: begin
                dst = rd;
                wr  = 1'b1;
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h08: begin wr = 1'b0; npc = a; end
                    6'h09: begin res = mpc + 32'd4; npc = a; end
                    default: wr = 1'b0;
                endcase
            end
            6'h1C: if (fn == 6'h02) begin res = a * b; wr = 1'b1; dst = rd; end
            6'h08, 6'h09: begin res = a + simm; wr = 1'b1; end
            6'h0A: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; wr = 1'b1; end
            6'h0C: begin res = a & zimm; wr = 1'b1; end
            6'h0D: begin res = a | zimm; wr = 1'b1; end
            6'h0E: begin res = a ^ zimm; wr = 1'b1; end
            6'h0F: begin res = {ins[15:0], 16'h0}; wr = 1'b1; end
            6'h23: begin res = mmem[addr[13:2]]; wr = 1'b1; end
            6'h2B: mmem[addr[13:2]] = b;
            6'h04: if (a == b) npc = mpc + 32'd4 + (simm << 2);
            6'h05: if (a != b) npc = mpc + 32'd4 + (simm << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin
                res = mpc + 32'd4;
                wr  = 1'b1;
                dst = 31;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        if (wr && dst != 0) mreg[dst] = res;
        mpc = npc;
    endtask

    task automatic compare_state();
        check("pc", pc_o, mpc);
        for (int r = 1; r < 32; r++) begin
            check($sformatf("r%0d", r), dut.u_regfile.regs[r], mreg[r]);
        end
    endtask

    task automatic compare_mem();
        int diffs;
        diffs = 0;
        for (int i = 0; i < 4096; i++) begin
            if (dut.mem[i] !== mmem[i]) diffs++;
        end
        check("mem_image_diffs", 32'(diffs), 32'd0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 32'h0;
    endtask

    // Load the image into DUT and model memory under reset, hold reset
    // two cycles, release on a falling edge.
    task automatic load_and_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            dut.mem[i] = 32'h0;
            mmem[i]    = 32'h0;
        end
        for (int i = 0; i < 64; i++) begin
            dut.mem[i] = img[i];
            mmem[i]    = img[i];
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("pc_in_reset", pc_o, 32'h0);
        check("sp_in_reset", dut.u_regfile.regs[29], 32'h0000_3FFC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int max_cycles, input bit expect_halt,
                            input logic [31:0] exp_pcs[$]);
        bit          halted;
        logic [31:0] prev;
        halted = 1'b0;
        for (int n = 0; n < max_cycles && !halted; n++) begin
            @(posedge clk);
            #1;
            prev = mpc;
            model_step();
            compare_state();
            if (n < exp_pcs.size()) check($sformatf("pc_seq%0d", n), pc_o, exp_pcs[n]);
            if (mpc == prev) halted = 1'b1;
        end
        if (expect_halt) check("reached_halt", 32'(halted), 32'd1);
    endtask

    logic [31:0] no_pcs[$];
    logic [31:0] seq[$];

    initial begin
        // ---------------- ALU sequence ----------------
        clear_img();
        img[0]  = enc_i(8, 0, 8, 5);
        img[1]  = enc_i(8, 0, 9, -3);
        img[2]  = enc_r(8, 9, 10, 0, 'h20);
        img[3]  = enc_r(9, 8, 11, 0, 'h2A);
        img[4]  = enc_mul(8, 8, 12);
        img[5]  = enc_i('h0F, 0, 13, 'h1234);
        img[6]  = enc_i('h0D, 13, 13, 'hABCD);
        img[7]  = enc_r(8, 9, 14, 0, 'h23);
        img[8]  = enc_r(0, 9, 15, 1, 'h03);
        img[9]  = enc_r(0, 9, 16, 28, 'h02);
        img[10] = enc_r(0, 8, 17, 4, 'h00);
        img[11] = enc_r(0, 0, 18, 0, 'h27);
        img[12] = enc_r(8, 9, 19, 0, 'h2B);
        img[13] = enc_i('h0E, 9, 20, 'hFFFF);
        img[14] = enc_i('h0C, 9, 21, 'h00F0);
        img[15] = enc_i('h0A, 9, 22, -2);
        img[16] = enc_i(9, 0, 23, 'h8000);
        img[17] = enc_i(8, 0, 0, 9);
        img[18] = enc_r(0, 8, 24, 0, 'h20);
        img[19] = enc_i(8, 9, 9, 1);
        img[20] = enc_r(9, 8, 25, 0, 'h22);
        img[21] = enc_r(13, 23, 26, 0, 'h24);
        img[22] = enc_r(8, 17, 27, 0, 'h25);
        img[23] = enc_r(10, 8, 28, 0, 'h26);
        img[24] = {6'h3F, 5'd0, 5'd5, 16'h0001};
        img[25] = enc_r(8, 8, 5, 0, 'h3F);
        img[26] = enc_j(2, 26);
        load_and_reset();
        seq = '{32'h4, 32'h8};
        run_prog(100, 1'b1, seq);
        check("alu_r10", dut.u_regfile.regs[10], 32'd2);
        check("alu_r11", dut.u_regfile.regs[11], 32'd1);
        check("alu_r12", dut.u_regfile.regs[12], 32'd25);
        check("alu_r13", dut.u_regfile.regs[13], 32'h1234_ABCD);
        check("alu_sra", dut.u_regfile.regs[15], 32'hFFFF_FFFE);
        check("alu_sltu", dut.u_regfile.regs[19], 32'd1);
        check("alu_xori", dut.u_regfile.regs[20], 32'hFFFF_0002);
        check("alu_addiu", dut.u_regfile.regs[23], 32'hFFFF_8000);
        check("alu_r0_src", dut.u_regfile.regs[24], 32'd5);
        check("alu_rw_same", dut.u_regfile.regs[9], 32'hFFFF_FFFE);
        check("alu_unknown", dut.u_regfile.regs[5], 32'd0);
        compare_mem();

        // ---------------- load/store ----------------
        clear_img();
        img[0] = enc_i(8, 0, 8, 'h2000);
        img[1] = enc_i(8, 0, 9, 7);
        img[2] = enc_i('h2B, 8, 9, 8);
        img[3] = enc_i('h23, 8, 10, 8);
        img[4] = enc_i('h23, 8, 11, 11);
        img[5] = enc_i('h2B, 0, 9, -4);
        img[6] = enc_i('h23, 0, 12, 'h3FFC);
        img[7] = enc_j(2, 7);
        load_and_reset();
        run_prog(100, 1'b1, no_pcs);
        check("ls_mem802", dut.mem[12'h802], 32'd7);
        check("ls_memfff", dut.mem[12'hFFF], 32'd7);
        check("ls_r10", dut.u_regfile.regs[10], 32'd7);
        check("ls_r11", dut.u_regfile.regs[11], 32'd7);
        check("ls_r12", dut.u_regfile.regs[12], 32'd7);
        compare_mem();

        // ---------------- branch and jump ----------------
        clear_img();
        img[0]  = enc_i(4, 0, 0, 2);
        img[1]  = enc_i(8, 0, 8, 1);
        img[2]  = enc_i(8, 0, 9, 1);
        img[3]  = enc_i(5, 0, 0, 5);
        img[4]  = enc_i(8, 0, 10, 3);
        img[5]  = enc_j(2, 'h10);
        img[6]  = enc_i(8, 0, 11, 1);
        img[16] = enc_i(8, 0, 12, 4);
        img[17] = enc_i(5, 12, 0, 1);
        img[18] = enc_i(8, 0, 13, 1);
        img[19] = enc_i(4, 12, 0, 1);
        img[20] = enc_i(8, 0, 14, 'h60);
        img[21] = enc_r(14, 0, 15, 0, 'h09);
        img[22] = enc_i(8, 0, 16, 1);
        img[24] = enc_i(4, 0, 0, -1);
        load_and_reset();
        seq = '{32'hC, 32'h10, 32'h14, 32'h40, 32'h44, 32'h4C, 32'h50, 32'h54, 32'h60, 32'h60};
        run_prog(100, 1'b1, seq);
        check("br_skip_r8", dut.u_regfile.regs[8], 32'd0);
        check("br_skip_r9", dut.u_regfile.regs[9], 32'd0);
        check("br_r10", dut.u_regfile.regs[10], 32'd3);
        check("br_skip_r11", dut.u_regfile.regs[11], 32'd0);
        check("br_skip_r13", dut.u_regfile.regs[13], 32'd0);
        check("jalr_link", dut.u_regfile.regs[15], 32'h58);
        check("jalr_skip", dut.u_regfile.regs[16], 32'd0);

        // ---------------- recursive factorial ----------------
        clear_img();
        img[0]  = enc_i(8, 0, 4, 5);
        img[1]  = enc_j(3, 4);
        img[2]  = enc_j(2, 2);
        img[4]  = enc_i(8, 29, 29, -8);
        img[5]  = enc_i('h2B, 29, 31, 4);
        img[6]  = enc_i('h2B, 29, 4, 0);
        img[7]  = enc_i('h0A, 4, 8, 2);
        img[8]  = enc_i(4, 8, 0, 3);
        img[9]  = enc_i(8, 0, 2, 1);
        img[10] = enc_i(8, 29, 29, 8);
        img[11] = enc_r(31, 0, 0, 0, 'h08);
        img[12] = enc_i(8, 4, 4, -1);
        img[13] = enc_j(3, 4);
        img[14] = enc_i('h23, 29, 4, 0);
        img[15] = enc_i('h23, 29, 31, 4);
        img[16] = enc_i(8, 29, 29, 8);
        img[17] = enc_mul(4, 2, 2);
        img[18] = enc_r(31, 0, 0, 0, 'h08);
        load_and_reset();
        run_prog(600, 1'b1, no_pcs);
        check("fact_r2", dut.u_regfile.regs[2], 32'd120);
        check("fact_sp", dut.u_regfile.regs[29], 32'h0000_3FFC);
        check("fact_pc", pc_o, 32'h8);
        compare_mem();

        // ---------------- reset mid-run ----------------
        load_and_reset();
        run_prog(20, 1'b0, no_pcs);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_o, 32'h0);
        model_reset();
        compare_state();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(600, 1'b1, no_pcs);
        check("rerun_r2", dut.u_regfile.regs[2], 32'd120);
        check("rerun_sp", dut.u_regfile.regs[29], 32'h0000_3FFC);
        compare_mem();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
